hall_sensor_ctrl: RTL and testbench

Front end for the rotation-synchronisation path. Takes the raw Hall effect sensor 1 signal, synchronises and de-glitches it, and measures the period of each mechanical turn in `clk` ticks. It produces the `speed_data` / `start_of_turn` pair consumed by the slice PLL and reports lock and stall status to the top level. Spurious edges, stalled motors and unstable start-up are filtered out here, so the PLL only ever sees plausible turns.

---
 rtl/hall_pkg.sv | 17 +
 rtl/hall_filter.sv | 38 +++
 rtl/hall_sensor_ctrl.sv | 97 +++++++++
 tb/tb_hall_sensor_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// hall_pkg: shared types for the Hall sensor front end.
package hall_pkg;

    typedef logic [31:0] tick_t;

    typedef enum logic [1:0] {
        HALL_IDLE,
        HALL_ARM,
        HALL_MEASURE,
        HALL_LOCKED
    } hall_state_e;

    function automatic tick_t abs_diff(input tick_t a, input tick_t b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// hall_filter: 2-FF synchroniser, run-length glitch filter and registered falling-edge pulse.
module hall_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hall_n,
    output logic fall_edge
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] run;
    logic          flip;

    // Level flips on the FILTER_LEN-th consecutive differing sample.
    assign flip = (sync[1] != level) && (run == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            level     <= 1'b1;
            level_q   <= 1'b1;
            run       <= '0;
            fall_edge <= 1'b0;
        end else begin
            sync      <= {sync[0], hall_n};
            run       <= (sync[1] == level || flip) ? '0 : run + 1'b1;
            level     <= flip ? sync[1] : level;
            level_q   <= level;
            fall_edge <= level_q & ~level;
        end
    end

endmodule

// File: rtl/hall_sensor_ctrl.sv
// hall_sensor_ctrl: measures turn period from the filtered Hall edge, tracks lock and stall.
module hall_sensor_ctrl
    import hall_pkg::*;
#(
    parameter int    FILTER_LEN = 4,
    parameter tick_t MIN_TICKS  = 32'd1000,
    parameter tick_t MAX_TICKS  = 32'd50_000_000,
    parameter int    LOCK_TURNS = 3,
    parameter int    TOL_SHIFT  = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hall_n,
    output tick_t speed_data,
    output logic  start_of_turn,
    output logic  locked,
    output logic  stalled
);

    localparam int GW = (LOCK_TURNS > 1) ? $clog2(LOCK_TURNS + 1) : 1;

    hall_state_e   state;
    tick_t         cnt;
    logic [GW-1:0] good;
    logic          fall_edge;
    logic          accept;
    logic          stall;
    logic          in_tol;

    hall_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .hall_n   (hall_n),
        .fall_edge(fall_edge)
    );

    // Blanking applies only once a reference period exists.
    assign accept = fall_edge && (state == HALL_IDLE || state == HALL_ARM || cnt >= MIN_TICKS);
    assign stall  = (state != HALL_IDLE) && (cnt >= MAX_TICKS) && !accept;
    assign in_tol = abs_diff(cnt, speed_data) <= (speed_data >> TOL_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HALL_IDLE;
            cnt           <= '0;
            good          <= '0;
            speed_data    <= '0;
            start_of_turn <= 1'b0;
            locked        <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            start_of_turn <= 1'b0;
            cnt           <= accept ? tick_t'(1) : (cnt >= MAX_TICKS) ? cnt : cnt + 1'b1;
            if (stall) begin
                state      <= HALL_IDLE;
                stalled    <= 1'b1;
                locked     <= 1'b0;
                speed_data <= '0;
                good       <= '0;
            end else if (accept) begin
                case (state)
                    HALL_IDLE: begin
                        state   <= HALL_ARM;
                        stalled <= 1'b0;
                    end
                    HALL_ARM: begin
                        start_of_turn <= 1'b1;
                        speed_data    <= cnt;
                        good          <= '0;
                        state         <= HALL_MEASURE;
                    end
                    HALL_MEASURE: begin
                        start_of_turn <= 1'b1;
                        speed_data    <= cnt;
                        good          <= in_tol ? good + 1'b1 : '0;
                        if (in_tol && good == GW'(LOCK_TURNS - 1)) begin
                            locked <= 1'b1;
                            state  <= HALL_LOCKED;
                        end
                    end
                    HALL_LOCKED: begin
                        start_of_turn <= 1'b1;
                        speed_data    <= cnt;
                        if (!in_tol) begin
                            locked <= 1'b0;
                            good   <= '0;
                            state  <= HALL_MEASURE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_sensor_ctrl.sv
// tb_hall_sensor_ctrl: directed + random turns checked against an edge-level reference model.
module tb_hall_sensor_ctrl;
    import hall_pkg::*;

    localparam int    FL    = 4;
    localparam tick_t MIN_T = 32'd100;
    localparam tick_t MAX_T = 32'd3000;
    localparam int    LT    = 3;
    localparam int    TS    = 4;
    localparam int    LAT   = FL + 3;

    typedef struct {
        int cyc;
        int sot;
        int spd;
        int lck;
        int stl;
    } ev_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  hall_n = 1'b1;
    tick_t speed_data;
    logic  start_of_turn, locked, stalled;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0, checks = 0, errors = 0, last_k = 0;
    int  m_phase = 0, m_last = 0, m_spd = 0, m_good = 0, m_lck = 0, m_stl = 0;
    bit  mon_en = 1'b0;
    logic prev_stl = 1'b0;

    hall_sensor_ctrl #(
        .FILTER_LEN(FL),
        .MIN_TICKS (MIN_T),
        .MAX_TICKS (MAX_T),
        .LOCK_TURNS(LT),
        .TOL_SHIFT (TS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_n       (hall_n),
        .speed_data   (speed_data),
        .start_of_turn(start_of_turn),
        .locked       (locked),
        .stalled      (stalled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every pulse and every change of stalled, with the cycle it became visible.
    always @(negedge clk) begin
        if (mon_en && (start_of_turn || stalled != prev_stl))
            obs_q.push_back('{cyc, int'(start_of_turn), int'(speed_data), int'(locked), int'(stalled)});
        prev_stl <= stalled;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_stall_upto(input int c);
        int t;
        t = m_last + LAT + int'(MAX_T);
        if (m_phase != 0 && t <= c) begin
            exp_q.push_back('{t, 0, 0, 0, 1});
            m_phase = 0;
            m_lck   = 0;
            m_spd   = 0;
            m_good  = 0;
            m_stl   = 1;
        end
    endfunction

    // k is the cycle at which the falling hall_n is first sampled.
    function automatic void model_edge(input int k);
        int gap, d;
        bit tol;
        model_stall_upto(k + LAT - 1);
        gap = k - m_last;
        if (m_phase == 0) begin
            m_last  = k;
            m_phase = 1;
            if (m_stl != 0) exp_q.push_back('{k + LAT, 0, 0, 0, 0});
            m_stl = 0;
        end else if (m_phase == 1) begin
            m_last  = k;
            m_spd   = gap;
            m_good  = 0;
            m_phase = 2;
            exp_q.push_back('{k + LAT, 1, gap, 0, 0});
        end else if (gap >= int'(MIN_T)) begin
            d      = (gap > m_spd) ? gap - m_spd : m_spd - gap;
            tol    = d <= (m_spd >> TS);
            m_last = k;
            if (m_phase == 2) begin
                m_good = tol ? m_good + 1 : 0;
                if (m_good >= LT) begin
                    m_lck   = 1;
                    m_phase = 3;
                end
            end else if (!tol) begin
                m_lck   = 0;
                m_good  = 0;
                m_phase = 2;
            end
            m_spd = gap;
            exp_q.push_back('{k + LAT, 1, gap, m_lck, 0});
        end
    endfunction

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic fall(input int gap, input bit glitch = 1'b0);
        int k;
        k = last_k + gap;
        if (glitch) begin
            wait_until(last_k + gap / 2 - 1);
            hall_n = 1'b0;
            wait_until(last_k + gap / 2 + 2);
            hall_n = 1'b1;
        end
        wait_until(k - 1);
        hall_n = 1'b0;
        model_edge(k);
        wait_until(k + 11);
        hall_n = 1'b1;
        last_k = k;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".speed"}, speed_data, 0);
        check({tag, ".sot"}, start_of_turn, 0);
        check({tag, ".locked"}, locked, 0);
        check({tag, ".stalled"}, stalled, 0);
    endtask

    initial begin
        int gap, base, r, n;
        bit gl;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        last_k = cyc;
        // Clean turns: lock on the fifth edge.
        fall(20);
        repeat (4) fall(800);
        // Glitch, blanking and the MIN boundary.
        fall(800, 1'b1);
        fall(40);
        fall(760);
        fall(99);
        fall(701);
        // Drift: 850 is exactly on the tolerance limit, 1000 is not.
        fall(850);
        fall(1000);
        repeat (3) fall(1000);
        // Stall while locked, then restart.
        fall(3400);
        fall(800);
        fall(800);
        fall(100);
        fall(3000);
        fall(800);
        repeat (3) fall(800);
        // Reset while locked.
        wait_until(last_k + 100);
        model_stall_upto(cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        m_phase = 0; m_lck = 0; m_spd = 0; m_good = 0; m_stl = 0;
        fall(500);
        fall(800);
        base = 900;
        for (int i = 0; i < 28; i++) begin
            r  = int'($urandom_range(0, 9));
            gl = 1'b0;
            if (r == 0) gap = int'($urandom_range(30, 140));
            else if (r == 1) gap = int'($urandom_range(2990, 3010));
            else begin
                if (r == 2) gl = 1'b1;
                if (r == 3) base = int'($urandom_range(700, 1200));
                gap = base + int'($urandom_range(0, 120)) - 60;
            end
            fall(gap, gl);
        end
        wait_until(last_k + 200);
        model_stall_upto(cyc);
        check("n_events", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("ev%0d.cyc", i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("ev%0d.sot", i), obs_q[i].sot, exp_q[i].sot);
            check($sformatf("ev%0d.speed", i), obs_q[i].spd, exp_q[i].spd);
            check($sformatf("ev%0d.locked", i), obs_q[i].lck, exp_q[i].lck);
            check($sformatf("ev%0d.stalled", i), obs_q[i].stl, exp_q[i].stl);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
